// File: rtl/beat_metronome.sv
// Beat regenerator: turns a BPM estimate into a free-running, phase-aligned beat
// pulse train, re-aligned by detector beat strobes and reporting lock status.
`timescale 1ns/1ps
module beat_metronome #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BPM_MIN    = 40,
  parameter int unsigned BPM_MAX    = 240,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bpm_in,
  input  logic        bpm_valid,
  input  logic        beat_sync,
  output logic        beat_pulse,
  output logic [7:0]  beat_count,
  output logic [31:0] period_cycles,
  output logic        busy,
  output logic        locked
);

  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ * 60);
  localparam logic [15:0] BMIN     = 16'(BPM_MIN);
  localparam logic [15:0] BMAX     = 16'(BPM_MAX);
  localparam int          LW       = $clog2(LOCK_COUNT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [15:0] clamp_bpm(input logic [15:0] v);
    if (v < BMIN) begin
      return BMIN;
    end else if (v > BMAX) begin
      return BMAX;
    end else begin
      return v;
    end
  endfunction

  // divider and pending-request state
  logic        busy_q, busy_d;
  logic [4:0]  iter_q, iter_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [15:0] dvs_q, dvs_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        div_done_s;
  logic [32:0] rem_sh_s;

  // beat generator state
  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     period_q, period_d;
  logic [31:0]     new_period_q, new_period_d;
  logic            np_vld_q, np_vld_d;
  logic            pulse_q, pulse_d;
  logic [7:0]      bcount_q, bcount_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d;
  logic            wrap_s, late_s, win_s;
  logic [LW-1:0]   lock_inc_s;

  assign rem_sh_s = {rem_q, quo_q[31]};
  assign wrap_s   = (cnt_q == period_q - 32'd1);
  assign late_s   = (cnt_q >= (period_q >> 1));
  assign win_s    = (cnt_q < (period_q >> 3)) || (cnt_q >= period_q - (period_q >> 3));

  // Restoring divider: one quotient bit per cycle; requests arriving while busy park in pend.
  always_comb begin
    busy_d     = busy_q;
    iter_d     = iter_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    div_done_s = 1'b0;
    if (busy_q) begin
      if (rem_sh_s >= {17'd0, dvs_q}) begin
        rem_d = rem_sh_s[31:0] - {16'd0, dvs_q};
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_sh_s[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      iter_d = iter_q + 5'd1;
      if (iter_q == 5'd31) begin
        busy_d     = 1'b0;
        div_done_s = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
      if (bpm_valid) begin
        pend_d     = clamp_bpm(bpm_in);
        pend_vld_d = 1'b1;
      end else begin
        pend_vld_d = pend_vld_q;
      end
    end else if (bpm_valid || pend_vld_q) begin
      busy_d     = 1'b1;
      iter_d     = 5'd0;
      rem_d      = 32'd0;
      quo_d      = DIVIDEND;
      dvs_d      = bpm_valid ? clamp_bpm(bpm_in) : pend_q;
      pend_vld_d = 1'b0;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Beat FSM: counter, pulse generation, period hand-over at restart and lock tracking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    new_period_d = new_period_q;
    np_vld_d     = np_vld_q;
    pulse_d      = 1'b0;
    bcount_d     = bcount_q;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;
    lock_inc_s   = (lock_cnt_q < LOCK_MAX) ? lock_cnt_q + LW'(1) : lock_cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (div_done_s) begin
          period_d = quo_d;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (wrap_s || (beat_sync && late_s)) begin
          pulse_d  = 1'b1;
          bcount_d = bcount_q + 8'd1;
        end else begin
          pulse_d = 1'b0;
        end
        if (wrap_s || beat_sync) begin
          cnt_d = 32'd0;
          if (np_vld_q) begin
            period_d = new_period_q;
            np_vld_d = 1'b0;
          end else begin
            period_d = period_q;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        if (beat_sync) begin
          if (win_s) begin
            lock_cnt_d = lock_inc_s;
            locked_d   = (lock_inc_s == LOCK_MAX);
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end
        end else begin
          locked_d = locked_q;
        end
        // a result finishing on a restart cycle waits for the following restart
        if (div_done_s) begin
          new_period_d = quo_d;
          np_vld_d     = 1'b1;
        end else begin
          new_period_d = new_period_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers for divider and beat FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= 1'b0;
      iter_q       <= 5'd0;
      rem_q        <= 32'd0;
      quo_q        <= 32'd0;
      dvs_q        <= 16'd0;
      pend_q       <= 16'd0;
      pend_vld_q   <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= 32'd0;
      period_q     <= 32'd0;
      new_period_q <= 32'd0;
      np_vld_q     <= 1'b0;
      pulse_q      <= 1'b0;
      bcount_q     <= 8'd0;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      iter_q       <= iter_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvs_q        <= dvs_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      new_period_q <= new_period_d;
      np_vld_q     <= np_vld_d;
      pulse_q      <= pulse_d;
      bcount_q     <= bcount_d;
      lock_cnt_q   <= lock_cnt_d;
      locked_q     <= locked_d;
    end
  end

  assign beat_pulse    = pulse_q;
  assign beat_count    = bcount_q;
  assign period_cycles = period_q;
  assign busy          = busy_q;
  assign locked        = locked_q;

endmodule

// File: tb/tb_beat_metronome.sv
// Bench for beat_metronome: directed stimulus with a pulse scoreboard and point checks.
`timescale 1ns/1ps
module tb_beat_metronome;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bpm_in;
  logic        bpm_valid;
  logic        beat_sync;
  logic        beat_pulse;
  logic [7:0]  beat_count;
  logic [31:0] period_cycles;
  logic        busy;
  logic        locked;

  beat_metronome #(.CLK_HZ(1000), .BPM_MIN(40), .BPM_MAX(240), .LOCK_COUNT(4)) dut (
    .clk(clk), .reset(reset), .bpm_in(bpm_in), .bpm_valid(bpm_valid), .beat_sync(beat_sync),
    .beat_pulse(beat_pulse), .beat_count(beat_count), .period_cycles(period_cycles),
    .busy(busy), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {int c; int bc;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // pulse monitor: each observed pulse must match the next expected (cycle, beat_count)
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL pulse_missing expected at cyc=%0d bc=%0d, still absent at cyc=%0d", mon_e.c, mon_e.bc, cyc);
    end
    if (beat_pulse) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected actual cyc=%0d beat_count=%0d required no pulse", cyc, beat_count);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.c || beat_count != 8'(mon_e.bc)) begin
          failures++;
          $display("FAIL pulse actual cyc=%0d beat_count=%0d required cyc=%0d beat_count=%0d",
                   cyc, beat_count, mon_e.c, mon_e.bc);
        end
      end
    end
  end

  task automatic push_pulse(input int c, input int bc);
    exp_t e;
    e.c = c;
    e.bc = bc;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", nm, act, req, cyc);
    end
  endtask

  task automatic send_bpm(input int t, input logic [15:0] v);
    wait_cyc(t);
    bpm_in = v;
    bpm_valid = 1'b1;
    @(negedge clk);
    bpm_valid = 1'b0;
  endtask

  task automatic send_sync(input int t);
    wait_cyc(t);
    beat_sync = 1'b1;
    @(negedge clk);
    beat_sync = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulse"}, {31'd0, beat_pulse}, 32'd0);
    chk({tag, "_count"}, {24'd0, beat_count}, 32'd0);
    chk({tag, "_period"}, period_cycles, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  int k0, r, s, k1, r2, k2;

  initial begin
    reset = 1'b1;
    bpm_in = 16'd0;
    bpm_valid = 1'b0;
    beat_sync = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // 120 BPM at 1 kHz -> 500 cycles; then 300 (clamps to 250) and 0 (clamps to 1500)
    k0 = 10;
    r = k0 + 33;
    push_pulse(r + 500, 1);
    push_pulse(r + 1000, 2);
    push_pulse(r + 1250, 3);
    push_pulse(r + 1500, 4);
    push_pulse(r + 3000, 5);
    push_pulse(r + 4500, 6);
    send_bpm(k0, 16'd120);
    wait_cyc(k0 + 1);  chk("busy_rise", {31'd0, busy}, 32'd1);
    wait_cyc(k0 + 32); chk("busy_last", {31'd0, busy}, 32'd1);
    chk("period_before_done", period_cycles, 32'd0);
    wait_cyc(k0 + 33); chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("period_500", period_cycles, 32'd500);
    send_bpm(r + 600, 16'd300);
    wait_cyc(r + 999);  chk("period_hold_500", period_cycles, 32'd500);
    wait_cyc(r + 1000); chk("period_clamp_250", period_cycles, 32'd250);
    send_bpm(r + 1300, 16'd0);
    wait_cyc(r + 1499); chk("period_hold_250", period_cycles, 32'd250);
    wait_cyc(r + 1500); chk("period_clamp_1500", period_cycles, 32'd1500);
    send_bpm(r + 3100, 16'd120);
    wait_cyc(r + 4500); chk("period_back_500", period_cycles, 32'd500);

    // phase alignment and lock with P=500, counter 0 at cycle s
    s = r + 4500;
    push_pulse(s + 301, 7);
    push_pulse(s + 902, 8);
    push_pulse(s + 1402, 9);
    push_pulse(s + 1902, 10);
    push_pulse(s + 2402, 11);
    push_pulse(s + 2902, 12);
    push_pulse(s + 3153, 13);
    push_pulse(s + 3653, 14);
    send_sync(s + 300);
    chk("locked_after_late_sync", {31'd0, locked}, 32'd0);
    send_sync(s + 401);
    send_sync(s + 1401);
    send_sync(s + 1901);
    send_sync(s + 2401);
    wait_cyc(s + 2402); chk("locked_after_3", {31'd0, locked}, 32'd0);
    send_sync(s + 2901);
    wait_cyc(s + 2902); chk("locked_after_4", {31'd0, locked}, 32'd1);
    wait_cyc(s + 3000); chk("locked_holds", {31'd0, locked}, 32'd1);
    send_sync(s + 3152);
    wait_cyc(s + 3153); chk("locked_lost", {31'd0, locked}, 32'd0);

    // asynchronous reset in RUN
    wait_cyc(s + 3700);
    chk("count_before_reset", {24'd0, beat_count}, 32'd14);
    reset = 1'b1;
    #1;
    chk_all_zero("reset_run");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // pending register: 100 -> 600 first, then 200 -> 300; 150 is overwritten
    k1 = s + 3710;
    r2 = k1 + 33;
    push_pulse(r2 + 600, 1);
    push_pulse(r2 + 900, 2);
    push_pulse(r2 + 1200, 3);
    send_bpm(k1, 16'd100);
    send_bpm(k1 + 5, 16'd150);
    send_bpm(k1 + 10, 16'd200);
    wait_cyc(k1 + 33); chk("pend_period_600", period_cycles, 32'd600);
    chk("pend_busy_gap", {31'd0, busy}, 32'd0);
    wait_cyc(k1 + 34); chk("pend_busy_restart", {31'd0, busy}, 32'd1);
    wait_cyc(k1 + 65); chk("pend_busy_last", {31'd0, busy}, 32'd1);
    wait_cyc(k1 + 66); chk("pend_busy_fall", {31'd0, busy}, 32'd0);
    chk("pend_period_hold", period_cycles, 32'd600);
    wait_cyc(r2 + 599); chk("pend_period_hold2", period_cycles, 32'd600);
    wait_cyc(r2 + 600); chk("pend_period_300", period_cycles, 32'd300);

    // asynchronous reset mid-divide with a pending value, then syncs in IDLE
    k2 = r2 + 1250;
    send_bpm(k2, 16'd120);
    send_bpm(k2 + 5, 16'd60);
    wait_cyc(k2 + 10);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("reset_div");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(k2 + 14); chk("no_restart_busy", {31'd0, busy}, 32'd0);
    send_sync(k2 + 20);
    send_sync(k2 + 40);
    wait_cyc(k2 + 700);
    chk_all_zero("idle_after_abort");
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/beat_metronome.md
Name: beat_metronome

Overview:
- Consumes the BPM estimate and beat-detect strobes produced by the BPM estimation chain. Regenerates a steady, phase-aligned beat pulse train in the system clock domain for downstream consumers such as VGA face animation and LEDs.
- Converts BPM to a period in clock cycles with an iterative divider, then free-runs a period counter.
- Re-aligns the counter phase on detector beats and reports lock status.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; CLK_HZ*60 must fit in 32 bits.
- BPM_MIN, 40, lowest accepted BPM; lower inputs, including 0, are clamped to this value.
- BPM_MAX, 240, highest accepted BPM; higher inputs are clamped to this value.
- LOCK_COUNT, 4, consecutive in-tolerance syncs required to assert locked.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bpm_in  in  16  BPM estimate (unsigned integer)
- bpm_valid  in  1  single-cycle strobe qualifying bpm_in
- beat_sync  in  1  single-cycle detector beat strobe used for phase alignment
- beat_pulse  out  1  single-cycle regenerated beat
- beat_count  out  8  running beat counter; wraps 255->0
- period_cycles  out  32  active beat period in clk cycles
- busy  out  1  divider running
- locked  out  1  phase-locked to beat_sync

Behaviour:
- Reset (asynchronous, active-high) forces:
  - all outputs to 0
  - FSM to IDLE
  - counter, pending register, divider and lock count to 0
- Clamp: b = min(max(bpm_in, BPM_MIN), BPM_MAX), applied when bpm_valid is sampled.
- Divider: restoring, 1 quotient bit per cycle, 32 iterations.
  - Dividend is the constant CLK_HZ*60; divisor is b; quotient is truncated.
  - busy rises the cycle after bpm_valid and stays high exactly 32 cycles.
  - The result is written to new_period 33 cycles after the bpm_valid edge; busy falls in that same cycle.
- bpm_valid while busy: the value goes to a 1-deep pending register, with the last value winning. When the current divide finishes, a new divide starts from the pending value on the next cycle.
- FSM states:
  - IDLE: period_cycles = 0, no pulses, counter held at 0. On first divide completion, load period_cycles = new_period, set counter = 0, go to RUN.
  - RUN: counter increments every cycle. When counter == period_cycles-1:
    - beat_pulse = 1 for that cycle
    - counter <= 0
    - beat_count += 1
    - any completed-but-unapplied new_period is loaded into period_cycles at this wrap, so no shortened or glitched beat occurs
  - There is no return to IDLE except by reset.
- First pulse: period_cycles cycles after entering RUN (counter 0..P-1).
- beat_sync in RUN, with P = period_cycles and c = counter:
  - c >= P>>1 (late half): beat_pulse = 1 this cycle, counter <= 0, beat_count += 1.
  - c < P>>1 (early half): counter <= 0, no pulse (that beat was already emitted).
  - Tolerance window: c < P>>3 or c >= P-(P>>3).
    - In window: lock count increments (saturating at LOCK_COUNT); locked = 1 when it reaches LOCK_COUNT.
    - Outside window: lock count <= 0, locked <= 0.
  - A sync coinciding with a natural wrap produces one pulse only.
- beat_sync in IDLE is ignored.
- Simultaneous bpm_valid and beat_sync: both are processed independently.
- A pending period load and a sync-induced reset in the same cycle: the period is loaded and counter <= 0.
- Reset mid-divide: the divide is aborted, the pending value is discarded, and the FSM returns to IDLE.

Test Plan:
- CLK_HZ=1000; reset, then bpm_valid with bpm_in=120 -> busy high 32 cycles; period_cycles=500 at +33; pulses every 500 cycles, the first 500 cycles after entering RUN; beat_count increments per pulse.
- bpm_in=300, then later bpm_in=0 -> clamped periods of 250 and 1500; the new period takes effect only at the next wrap (the previous interval is unchanged).
- In RUN with P=500: beat_sync at c=300 -> immediate pulse, counter 0. beat_sync at c=100 -> no pulse, counter 0, next pulse 500 cycles later.
- Drive beat_sync every 500 cycles aligned to the wraps, 4 times -> locked=1 after the 4th. Then a sync at c=250 -> locked=0.
- bpm_valid 100, then 150 during busy, then 200 during busy -> 600 loaded first; a second divide uses 200 (result 300); 150 is never used.
- Assert reset mid-divide and mid-RUN -> all outputs 0 immediately (asynchronous); no pulses until a new bpm_valid completes a divide.
